// File: rtl/fetch_pkg.sv
// Shared fetch-path definitions: PC select/source codes, sequencer states, control payload.
package fetch_pkg;

  localparam int unsigned SEL_W   = 2;
  localparam int unsigned PLACE_W = 4;
  localparam int unsigned IDX_W   = 3;
  localparam int unsigned CNT_W   = 3;

  // pc_select codes
  localparam logic [SEL_W-1:0] SEL_HOLD = 2'b00;
  localparam logic [SEL_W-1:0] SEL_INC1 = 2'b01;
  localparam logic [SEL_W-1:0] SEL_INC2 = 2'b10;

  // pc_place codes
  localparam logic [PLACE_W-1:0] PLACE_SEQ  = 4'b0000;
  localparam logic [PLACE_W-1:0] PLACE_ZERO = 4'b0001;
  localparam logic [PLACE_W-1:0] PLACE_IVT  = 4'b0101;
  localparam logic [PLACE_W-1:0] PLACE_RET  = 4'b0110;
  localparam logic [PLACE_W-1:0] PLACE_CALL = 4'b0111;
  localparam logic [PLACE_W-1:0] PLACE_INST = 4'b1000;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_SAVE = 2'd1,
    ST_VECT = 2'd2,
    ST_HALT = 2'd3
  } seq_state_e;

  // Control word presented to the fetch stage each cycle
  typedef struct packed {
    logic [SEL_W-1:0]   sel;
    logic [PLACE_W-1:0] place;
    logic               flush;
    logic               save_pc;
    logic               int_ack;
  } seq_ctrl_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Decode-to-sequencer request lines and sequencer-to-fetch control lines.
interface fetch_sequencer_if;
  import fetch_pkg::*;

  logic               stall;
  logic               wide_inst;
  logic               jmp_taken;
  logic               call_req;
  logic               ret_req;
  logic               hlt;
  logic               int_req;
  logic [IDX_W-1:0]   int_index_in;

  logic [SEL_W-1:0]   pc_select;
  logic [PLACE_W-1:0] pc_place;
  logic [IDX_W-1:0]   index;
  logic               int_ack;
  logic               flush;
  logic               save_pc;

  modport master (
    output stall, wide_inst, jmp_taken, call_req, ret_req, hlt, int_req, int_index_in,
    input  pc_select, pc_place, index, int_ack, flush, save_pc
  );

  modport slave (
    input  stall, wide_inst, jmp_taken, call_req, ret_req, hlt, int_req, int_index_in,
    output pc_select, pc_place, index, int_ack, flush, save_pc
  );

endinterface

// File: rtl/int_latch.sv
// Interrupt pending flag and vector index capture; the acknowledge clear beats a new request.
module int_latch
  import fetch_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             int_req,
  input  logic [IDX_W-1:0] int_index_in,
  input  logic             clr,
  output logic             pending,
  output logic [IDX_W-1:0] index
);

  logic             pending_q, pending_d;
  logic [IDX_W-1:0] index_q, index_d;

  // Capture only when nothing is pending; later requests wait for the clear
  always_comb begin
    pending_d = pending_q;
    index_d   = index_q;
    if (clr) begin
      pending_d = 1'b0;
    end else if (!pending_q && int_req) begin
      pending_d = 1'b1;
      index_d   = int_index_in;
    end
  end

  // Pending/index registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= 1'b0;
      index_q   <= '0;
    end else begin
      pending_q <= pending_d;
      index_q   <= index_d;
    end
  end

  assign pending = pending_q;
  assign index   = index_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch PC sequencer: chooses the next-PC source each cycle and runs the interrupt
// save/vector sequence. Define FETCH_SEQ_INT_EN to build the interrupt logic
// (pending latch, save counter, SAVE and VECT); without it int_req is ignored and
// HALT is left only through reset.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned INT_SAVE_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  fetch_sequencer_if.slave bus
);

  seq_state_e       state_q, state_d;
  seq_ctrl_t        ctrl_c;
  logic             pending_c;
  logic [IDX_W-1:0] index_c;
  logic             take_int_c;
  logic             int_ack_c;

`ifdef FETCH_SEQ_INT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  int_latch u_int_latch (
    .clk          (clk),
    .rst          (rst),
    .int_req      (bus.int_req),
    .int_index_in (bus.int_index_in),
    .clr          (int_ack_c),
    .pending      (pending_c),
    .index        (index_c)
  );

  // Save-phase cycle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_int;

  assign pending_c  = 1'b0;
  assign index_c    = '0;
  assign unused_int = ^{bus.int_req, bus.int_index_in, CNT_W'(INT_SAVE_CYCLES)};
`endif

  // A pending interrupt is only taken from RUN once the hazard stall clears
  assign take_int_c = pending_c & ~bus.stall;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
`ifdef FETCH_SEQ_INT_EN
    cnt_d   = '0;
`endif
    unique case (state_q)
      ST_RUN: begin
        if (take_int_c) begin
          state_d = ST_SAVE;
        end else if (bus.hlt &&
                     !(bus.ret_req || bus.call_req || bus.jmp_taken || bus.stall)) begin
          state_d = ST_HALT;
        end
      end
`ifdef FETCH_SEQ_INT_EN
      ST_SAVE: begin
        if (cnt_q == CNT_W'(INT_SAVE_CYCLES - 1)) begin
          state_d = ST_VECT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_VECT: begin
        state_d = ST_RUN;
      end
      ST_HALT: begin
        if (pending_c) begin
          state_d = ST_SAVE;
        end
      end
`else
      ST_HALT: begin
        state_d = ST_HALT;
      end
`endif
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Output decode from state and current requests; reset forces the load-0 vector
  always_comb begin
    ctrl_c       = '0;
    ctrl_c.sel   = SEL_INC1;
    ctrl_c.place = PLACE_SEQ;
    if (rst) begin
      ctrl_c.sel   = SEL_HOLD;
      ctrl_c.place = PLACE_ZERO;
      ctrl_c.flush = 1'b1;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (take_int_c) begin
            ctrl_c.sel = SEL_HOLD;
          end else if (bus.ret_req) begin
            ctrl_c.place = PLACE_RET;
            ctrl_c.flush = 1'b1;
          end else if (bus.call_req) begin
            ctrl_c.place = PLACE_CALL;
            ctrl_c.flush = 1'b1;
          end else if (bus.jmp_taken) begin
            ctrl_c.place = PLACE_INST;
            ctrl_c.flush = 1'b1;
          end else if (bus.stall || bus.hlt) begin
            ctrl_c.sel = SEL_HOLD;
          end else if (bus.wide_inst) begin
            ctrl_c.sel = SEL_INC2;
          end
        end
`ifdef FETCH_SEQ_INT_EN
        ST_SAVE: begin
          ctrl_c.sel     = SEL_HOLD;
          ctrl_c.save_pc = 1'b1;
          ctrl_c.flush   = 1'b1;
        end
        ST_VECT: begin
          ctrl_c.sel     = SEL_HOLD;
          ctrl_c.place   = PLACE_IVT;
          ctrl_c.int_ack = 1'b1;
          ctrl_c.flush   = 1'b1;
        end
`endif
        default: begin
          ctrl_c.sel = SEL_HOLD;
        end
      endcase
    end
  end

  assign int_ack_c     = ctrl_c.int_ack;
  assign bus.pc_select = ctrl_c.sel;
  assign bus.pc_place  = ctrl_c.place;
  assign bus.flush     = ctrl_c.flush;
  assign bus.save_pc   = ctrl_c.save_pc;
  assign bus.int_ack   = int_ack_c;
  assign bus.index     = rst ? '0 : index_c;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a rule-level model predicts each cycle's
// control outputs, a negedge monitor compares them against the DUT.
module tb_fetch_sequencer;

  localparam int unsigned NSAVE = 2;
`ifdef FETCH_SEQ_INT_EN
  localparam bit INT_EN = 1'b1;
`else
  localparam bit INT_EN = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] place;
    logic [1:0] sel;
    logic       chk_sel;
    logic       flush;
    logic       save_pc;
    logic       int_ack;
    logic [2:0] index;
  } exp_t;

  typedef enum int { M_RUN, M_SAVE, M_VECT, M_HALT } mode_e;

  logic clk;
  logic rst;
  fetch_sequencer_if bus_if ();

  fetch_sequencer #(.INT_SAVE_CYCLES(NSAVE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // stimulus variables
  bit       s_rst, s_stall, s_wide, s_jmp, s_call, s_ret, s_hlt, s_int;
  bit [2:0] s_iidx;

  // model state
  mode_e    m_mode;
  bit       m_pend;
  bit [2:0] m_idx;
  int       m_left;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, cyc, act, want);
    end
  endtask

  // Behavioural model: outputs for this cycle, then the state after the edge
  task automatic model_step(output exp_t e);
    mode_e nxt;
    bit    clr;
    e.place = 4'd0; e.sel = 2'd1; e.chk_sel = 1'b1;
    e.flush = 1'b0; e.save_pc = 1'b0; e.int_ack = 1'b0; e.index = m_idx;
    if (s_rst) begin
      e.place = 4'd1; e.sel = 2'd0; e.flush = 1'b1; e.index = 3'd0;
      m_mode = M_RUN; m_pend = 1'b0; m_idx = 3'd0; m_left = 0;
      return;
    end
    nxt = m_mode;
    clr = 1'b0;
    case (m_mode)
      M_RUN: begin
        if (m_pend && !s_stall) begin
          e.sel = 2'd0; nxt = M_SAVE; m_left = NSAVE;
        end else if (s_ret) begin
          e.place = 4'd6; e.flush = 1'b1; e.chk_sel = 1'b0;
        end else if (s_call) begin
          e.place = 4'd7; e.flush = 1'b1; e.chk_sel = 1'b0;
        end else if (s_jmp) begin
          e.place = 4'd8; e.flush = 1'b1; e.chk_sel = 1'b0;
        end else if (s_stall) begin
          e.sel = 2'd0;
        end else if (s_hlt) begin
          e.sel = 2'd0; nxt = M_HALT;
        end else if (s_wide) begin
          e.sel = 2'd2;
        end
      end
      M_SAVE: begin
        e.sel = 2'd0; e.flush = 1'b1; e.save_pc = 1'b1;
        m_left = m_left - 1;
        if (m_left == 0) nxt = M_VECT;
      end
      M_VECT: begin
        e.place = 4'd5; e.chk_sel = 1'b0; e.int_ack = 1'b1; e.flush = 1'b1;
        nxt = M_RUN; clr = 1'b1;
      end
      default: begin
        e.sel = 2'd0;
        if (m_pend) begin
          nxt = M_SAVE; m_left = NSAVE;
        end
      end
    endcase
    if (clr) begin
      m_pend = 1'b0;
    end else if (INT_EN && !m_pend && s_int) begin
      m_pend = 1'b1;
      m_idx  = s_iidx;
    end
    m_mode = nxt;
  endtask

  // Drive one cycle of stimulus and queue the predicted response
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    rst                 = s_rst;
    bus_if.stall        = s_stall;
    bus_if.wide_inst    = s_wide;
    bus_if.jmp_taken    = s_jmp;
    bus_if.call_req     = s_call;
    bus_if.ret_req      = s_ret;
    bus_if.hlt          = s_hlt;
    bus_if.int_req      = s_int;
    bus_if.int_index_in = s_iidx;
    model_step(e);
    exp_q.push_back(e);
  endtask

  task automatic clear_stim();
    s_rst = 0; s_stall = 0; s_wide = 0; s_jmp = 0;
    s_call = 0; s_ret = 0; s_hlt = 0; s_int = 0; s_iidx = 3'd0;
  endtask

  task automatic idle(input int n);
    clear_stim();
    for (int i = 0; i < n; i++) tick();
  endtask

  // Monitor: compare the DUT's presented outputs with the oldest prediction
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      cyc++;
      chk("pc_place", 32'(bus_if.pc_place), 32'(mon_e.place));
      if (mon_e.chk_sel) chk("pc_select", 32'(bus_if.pc_select), 32'(mon_e.sel));
      chk("flush",    32'(bus_if.flush),    32'(mon_e.flush));
      chk("save_pc",  32'(bus_if.save_pc),  32'(mon_e.save_pc));
      chk("int_ack",  32'(bus_if.int_ack),  32'(mon_e.int_ack));
      chk("index",    32'(bus_if.index),    32'(mon_e.index));
    end
  end

  initial begin
    rst = 1'b1;
    bus_if.stall = 0; bus_if.wide_inst = 0; bus_if.jmp_taken = 0; bus_if.call_req = 0;
    bus_if.ret_req = 0; bus_if.hlt = 0; bus_if.int_req = 0; bus_if.int_index_in = 3'd0;
    m_mode = M_RUN; m_pend = 0; m_idx = 3'd0; m_left = 0;

    // reset and release
    clear_stim(); s_rst = 1;
    repeat (3) tick();
    idle(3);

    // sequencing: wide, stall, jump under stall, call, ret
    clear_stim(); s_wide = 1; tick(); tick();
    clear_stim(); s_stall = 1; tick(); tick();
    s_jmp = 1; tick();
    clear_stim(); s_call = 1; tick();
    clear_stim(); s_ret = 1; tick();
    idle(2);

    // interrupt pulse, index 5
    clear_stim(); s_int = 1; s_iidx = 3'd5; tick();
    idle(6);

    // interrupt becomes pending while ret is requested
    clear_stim(); s_int = 1; s_iidx = 3'd3; s_ret = 1; tick();
    clear_stim(); s_ret = 1; tick(); tick();
    idle(5);

    // interrupt arriving under stall is deferred
    clear_stim(); s_stall = 1; s_int = 1; s_iidx = 3'd4; tick();
    s_int = 0;
    repeat (4) tick();
    idle(6);

    // halt, ignored requests, then interrupt index 2
    clear_stim(); s_hlt = 1; tick();
    for (int i = 0; i < 5; i++) begin
      clear_stim(); s_ret = 1; s_jmp = (i % 2 == 0); s_call = (i == 3); s_wide = 1;
      tick();
    end
    clear_stim(); s_int = 1; s_iidx = 3'd2; tick();
    idle(6);
    clear_stim(); s_rst = 1; tick(); tick();
    idle(2);

    // reset asserted in the middle of SAVE
    clear_stim(); s_int = 1; s_iidx = 3'd6; tick();
    idle(2);
    clear_stim(); s_rst = 1; tick(); tick();
    idle(4);

    // request held high across the acknowledge re-latches afterwards
    clear_stim(); s_int = 1; s_iidx = 3'd7;
    repeat (10) tick();
    s_iidx = 3'd1;
    repeat (4) tick();
    idle(6);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      s_rst   = ($urandom_range(0, 63) == 0);
      s_stall = ($urandom_range(0, 3) == 0);
      s_wide  = ($urandom_range(0, 3) == 0);
      s_jmp   = ($urandom_range(0, 5) == 0);
      s_call  = ($urandom_range(0, 7) == 0);
      s_ret   = ($urandom_range(0, 7) == 0);
      s_hlt   = ($urandom_range(0, 15) == 0);
      s_int   = ($urandom_range(0, 7) == 0);
      s_iidx  = 3'($urandom_range(0, 7));
      tick();
    end
    idle(2);

    // every prediction must have been consumed
    repeat (3) @(negedge clk);
    chk("drain", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
